// File: rtl/demux_1xn_stream_if.sv
// Stream bundle between one producer, the 1-to-N demux and N consumers.
// master = producer/consumer side, slave = demux side.
interface demux_1xn_stream_if #(
  parameter int N = 4,
  parameter int W = 1
);
  localparam int SEL_W = $clog2(N);

  // Handshake: a beat moves on a rising clk edge where valid && ready are
  // both high; each out_valid/out_ready bit pair is an independent channel.
  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_data;
  logic [SEL_W-1:0]     in_sel;
  logic                 in_bcast;
  logic [N-1:0]         out_valid;
  logic [N-1:0]         out_ready;
  logic [N*W-1:0]       out_data;

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_1xn_stream.sv
// Registered 1-to-N stream demultiplexer, one single-entry register per channel.
// Define DEMUX_BCAST_EN to build the broadcast path driven by in_bcast.
module demux_1xn_stream #(
  parameter int N = 4,
  parameter int W = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  demux_1xn_stream_if.slave    s,
  output logic                 err_oor,
  input  logic                 err_clr
);
  localparam int SEL_W = $clog2(N);

  logic [N-1:0]          vld;
  logic [N-1:0][W-1:0]   dat;
  logic [N-1:0]          free;
  logic [N-1:0]          load;
  logic                  sel_hit;
  logic                  uni_ready;
  logic                  bcast;
  logic                  accept;
  logic                  oor_accept;

  // A channel can take a beat if empty or if its current beat leaves this cycle.
  assign free = ~vld | s.out_ready;

  // Out-of-range selects match no channel and are always accepted (then dropped).
  always_comb begin
    sel_hit   = 1'b0;
    uni_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (s.in_sel == SEL_W'(k)) begin
        sel_hit   = 1'b1;
        uni_ready = free[k];
      end
    end
  end

`ifdef DEMUX_BCAST_EN
  assign bcast      = s.in_bcast;
  assign s.in_ready = s.in_bcast ? (&free) : uni_ready;
`else
  logic unused_bcast;
  assign unused_bcast = s.in_bcast;
  assign bcast        = 1'b0;
  assign s.in_ready   = uni_ready;
`endif

  assign accept     = s.in_valid && s.in_ready;
  assign oor_accept = accept && !bcast && !sel_hit;

  always_comb begin
    load = '0;
    for (int k = 0; k < N; k++) begin
      load[k] = accept && (bcast || (s.in_sel == SEL_W'(k)));
    end
  end

  // Load wins over pop, giving one beat per cycle per channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld     <= '0;
      dat     <= '0;
      err_oor <= 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (load[k]) begin
          vld[k] <= 1'b1;
          dat[k] <= s.in_data;
        end else if (s.out_ready[k]) begin
          vld[k] <= 1'b0;
          dat[k] <= '0;
        end
      end
      if (oor_accept) begin
        err_oor <= 1'b1;
      end else if (err_clr) begin
        err_oor <= 1'b0;
      end
    end
  end

  always_comb begin
    s.out_valid = vld;
    s.out_data  = '0;
    for (int k = 0; k < N; k++) begin
      s.out_data[k*W +: W] = vld[k] ? dat[k] : '0;
    end
  end
endmodule

// File: tb/tb_demux_1xn_stream.sv
// Bench for demux_1xn_stream: a 4-channel and a 5-channel instance, both W=8,
// checked every cycle against a per-channel queue model plus literal pins.
module tb_demux_1xn_stream;
`ifdef DEMUX_BCAST_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  // ---------------- stimulus arrays (index 0: N=4, index 1: N=5) ----------------
  logic        ival [2];
  logic [2:0]  isel [2];
  logic [7:0]  idat [2];
  logic        ibc  [2];
  logic [4:0]  ordy [2];
  logic        eclr [2];

  logic        irdy [2];
  logic [4:0]  ovld [2];
  logic [39:0] odat [2];
  logic        oerr [2];

  demux_1xn_stream_if #(.N(4), .W(8)) if4 ();
  demux_1xn_stream_if #(.N(5), .W(8)) if5 ();
  logic err4, err5;

  assign if4.in_valid  = ival[0];
  assign if4.in_sel    = isel[0][1:0];
  assign if4.in_data   = idat[0];
  assign if4.in_bcast  = ibc[0];
  assign if4.out_ready = ordy[0][3:0];
  assign if5.in_valid  = ival[1];
  assign if5.in_sel    = isel[1];
  assign if5.in_data   = idat[1];
  assign if5.in_bcast  = ibc[1];
  assign if5.out_ready = ordy[1];

  assign irdy[0] = if4.in_ready;
  assign ovld[0] = {1'b0, if4.out_valid};
  assign odat[0] = {8'h00, if4.out_data};
  assign oerr[0] = err4;
  assign irdy[1] = if5.in_ready;
  assign ovld[1] = if5.out_valid;
  assign odat[1] = if5.out_data;
  assign oerr[1] = err5;

  demux_1xn_stream #(.N(4), .W(8)) dut4 (
    .clk(clk), .rst(rst), .s(if4), .err_oor(err4), .err_clr(eclr[0])
  );
  demux_1xn_stream #(.N(5), .W(8)) dut5 (
    .clk(clk), .rst(rst), .s(if5), .err_oor(err5), .err_clr(eclr[1])
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel is a queue holding at most one pending beat.
  logic [7:0] exp_q [2][5][$];
  logic       merr  [2];

  function automatic bit model_ready(int d, int n);
    bit r;
    if (BC && ibc[d]) begin
      r = 1'b1;
      for (int k = 0; k < n; k++) r &= (exp_q[d][k].size() == 0) || ordy[d][k];
    end else if (int'(isel[d]) < n) begin
      r = (exp_q[d][isel[d]].size() == 0) || ordy[d][isel[d]];
    end else begin
      r = 1'b1;
    end
    return r;
  endfunction

  task automatic model_step(int d, int n);
    bit acc, bc, oor;
    acc = ival[d] && model_ready(d, n);
    bc  = BC && ibc[d];
    oor = acc && !bc && (int'(isel[d]) >= n);
    for (int k = 0; k < n; k++)
      if (ordy[d][k] && exp_q[d][k].size() > 0) void'(exp_q[d][k].pop_front());
    if (acc && bc) begin
      for (int k = 0; k < n; k++) exp_q[d][k].push_back(idat[d]);
    end else if (acc && !oor) begin
      exp_q[d][isel[d]].push_back(idat[d]);
    end
    if (oor) merr[d] = 1'b1;
    else if (eclr[d]) merr[d] = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        merr[d] = 1'b0;
        for (int k = 0; k < 5; k++) exp_q[d][k].delete();
      end
    end else begin
      model_step(0, 4);
      model_step(1, 5);
    end
  end

  // Compare process: mid low phase, after inputs have been stable since the edge.
  always @(negedge clk) begin
    int n;
    logic [4:0]  ev;
    logic [39:0] ed;
    #2;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        n  = (d == 0) ? 4 : 5;
        ev = '0;
        ed = '0;
        for (int k = 0; k < n; k++) begin
          if (exp_q[d][k].size() > 0) begin
            ev[k]         = 1'b1;
            ed[k*8 +: 8]  = exp_q[d][k][0];
          end
        end
        check((d == 0) ? "in_ready_n4" : "in_ready_n5", 64'(irdy[d]), 64'(model_ready(d, n)));
        check((d == 0) ? "out_valid_n4" : "out_valid_n5", 64'(ovld[d]), 64'(ev));
        check((d == 0) ? "out_data_n4" : "out_data_n5", 64'(odat[d]), 64'(ed));
        check((d == 0) ? "err_oor_n4" : "err_oor_n5", 64'(oerr[d]), 64'(merr[d]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic put(int d, bit v, int sel, int data);
    ival[d] = v;
    isel[d] = 3'(sel);
    idat[d] = 8'(data);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      put(d, 1'b0, 0, 0);
      ibc[d]  = 1'b0;
      eclr[d] = 1'b0;
    end
    ordy[0] = 5'h0F;
    ordy[1] = 5'h1F;
    rst = 1'b1;
    repeat (2) tick();
    check("reset_vld4", 64'(if4.out_valid), 64'h0);
    check("reset_dat4", 64'(if4.out_data), 64'h0);
    check("reset_err5", 64'(err5), 64'h0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // One beat to each channel on consecutive cycles.
    put(0, 1, 0, 'hA1); tick();
    check("seq_a1_vld", 64'(if4.out_valid), 64'h1);
    check("seq_a1_dat", 64'(if4.out_data), 64'h000000A1);
    put(0, 1, 1, 'hB2); tick();
    check("seq_b2_dat", 64'(if4.out_data), 64'h0000B200);
    put(0, 1, 2, 'hC3); tick();
    check("seq_c3_dat", 64'(if4.out_data), 64'h00C30000);
    put(0, 1, 3, 'hD4); tick();
    check("seq_d4_vld", 64'(if4.out_valid), 64'h8);
    check("seq_d4_dat", 64'(if4.out_data), 64'hD4000000);
    put(0, 0, 0, 0); tick();
    check("seq_idle_vld", 64'(if4.out_valid), 64'h0);

    // Stall channel 2 while channel 1 keeps flowing.
    ordy[0][2] = 1'b0;
    put(0, 1, 2, 'h11); tick();
    check("stall_first", 64'(if4.out_data), 64'h00110000);
    put(0, 1, 2, 'h22); #1;
    check("stall_ready", 64'(if4.in_ready), 64'h0);
    tick();
    check("stall_hold", 64'(if4.out_data), 64'h00110000);
    put(0, 1, 1, 'h33); #1;
    check("bypass_ready", 64'(if4.in_ready), 64'h1);
    tick();
    check("bypass_dat", 64'(if4.out_data), 64'h00113300);
    put(0, 1, 2, 'h22); ordy[0][2] = 1'b1; #1;
    check("release_ready", 64'(if4.in_ready), 64'h1);
    tick();
    check("release_dat", 64'(if4.out_data), 64'h00220000);
    put(0, 0, 0, 0); tick();

    // Back-to-back burst on channel 3.
    for (int i = 0; i < 8; i++) begin
      put(0, 1, 3, 'h40 + i); #1;
      check("burst_ready", 64'(if4.in_ready), 64'h1);
      tick();
      check("burst_dat", 64'(if4.out_data[31:24]), 64'('h40 + i));
      check("burst_vld", 64'(if4.out_valid), 64'h8);
    end
    put(0, 0, 0, 0); tick();

    // Out-of-range select on the 5-channel instance.
    put(1, 1, 6, 'hFF); #1;
    check("oor_ready", 64'(if5.in_ready), 64'h1);
    tick();
    check("oor_err", 64'(err5), 64'h1);
    check("oor_vld", 64'(if5.out_valid), 64'h0);
    put(1, 1, 7, 'h01); eclr[1] = 1'b1; tick();
    check("oor_set_over_clr", 64'(err5), 64'h1);
    put(1, 0, 0, 0); tick();
    check("oor_cleared", 64'(err5), 64'h0);
    eclr[1] = 1'b0;

    // Asynchronous reset in the middle of an accepting cycle.
    ordy[0][1] = 1'b0;
    put(0, 1, 1, 'h77);
    put(1, 1, 5, 'h00); tick();
    check("pre_rst_vld", 64'(if4.out_valid), 64'h2);
    check("pre_rst_err", 64'(err5), 64'h1);
    put(0, 1, 0, 'h12);
    put(1, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    check("arst_vld", 64'(if4.out_valid), 64'h0);
    check("arst_dat", 64'(if4.out_data), 64'h0);
    check("arst_err", 64'(err5), 64'h0);
    tick();
    put(0, 0, 0, 0);
    ordy[0] = 5'h0F;
    tick();
    rst = 1'b0;
    tick();

`ifdef DEMUX_BCAST_EN
    // Broadcast waits for every channel to be free.
    ordy[0][0] = 1'b0;
    put(0, 1, 0, 'h01); tick();
    put(0, 1, 0, 'h5A); ibc[0] = 1'b1; #1;
    check("bc_blocked", 64'(if4.in_ready), 64'h0);
    tick();
    check("bc_hold", 64'(if4.out_data), 64'h00000001);
    ordy[0][0] = 1'b1; #1;
    check("bc_ready", 64'(if4.in_ready), 64'h1);
    tick();
    check("bc_vld", 64'(if4.out_valid), 64'hF);
    check("bc_dat", 64'(if4.out_data), 64'h5A5A5A5A);
    put(0, 0, 0, 0); ibc[0] = 1'b0; tick();
`endif

    // Randomized traffic on both instances.
    repeat (600) begin
      for (int d = 0; d < 2; d++) begin
        put(d, $urandom_range(0, 3) != 0,
            (d == 0) ? $urandom_range(0, 3) : $urandom_range(0, 7),
            $urandom_range(0, 255));
        for (int k = 0; k < 5; k++) ordy[d][k] = ($urandom_range(0, 3) != 0);
        if (d == 0) ordy[d][4] = 1'b0;
        ibc[d]  = ($urandom_range(0, 7) == 0);
        eclr[d] = ($urandom_range(0, 15) == 0);
      end
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      put(d, 0, 0, 0);
      ibc[d]  = 1'b0;
      eclr[d] = 1'b0;
    end
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/demux_1xn_stream.md
Name: demux_1xn_stream

Overview:
- Parametrised, registered 1-to-N stream demultiplexer; next generation of the 1x4 combinational demux.
- Routes one input stream (data plus select) to one of N output channels using valid/ready handshakes.
- Each output channel has a single-entry output register.
- Unselected and idle outputs are driven to zero; no latched stale values.
- Sits between a single producer and N independent consumers in the datapath.

Parameters:
- N, 4, number of output channels; legal range 2..64.
- W, 1, data width in bits; legal range 1..256.
- SEL_W, $clog2(N), select width; localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready at a clk edge.
- in_data  input  W  input payload.
- in_sel  input  SEL_W  destination channel index.
- in_bcast  input  1  broadcast request; used only when DEMUX_BCAST_EN is defined, ignored otherwise.
- out_valid  output  N  per-channel valid; bit k belongs to channel k.
- out_ready  input  N  per-channel consumer ready.
- out_data  output  N*W  flattened payload; channel k occupies [k*W +: W].
- err_oor  output  1  sticky flag: an out-of-range select was accepted.
- err_clr  input  1  synchronous clear for err_oor.

Behaviour:
- Reset (async, rst=1): out_valid=0, all out_data=0, err_oor=0. Registers hold these values while rst is high. Deassertion takes effect at the next clk edge. A beat in flight during reset is lost.
- Per-channel state: vld[k], dat[k]. out_valid[k]=vld[k]. out_data channel k = dat[k] when vld[k]=1, otherwise 0.
- Channel k is free when (!vld[k] || out_ready[k]).
- Unicast in_ready:
  - in_sel < N: in_ready = free(in_sel).
  - in_sel >= N (possible only when N is not a power of 2): in_ready = 1.
- in_ready is combinational from in_sel and out_ready. No combinational path from in_valid to in_ready.
- Accept (in_valid && in_ready), in-range select: at that edge vld[in_sel]<=1 and dat[in_sel]<=in_data. All other channels are unaffected except for their own pops.
- Accept, out-of-range select: beat is dropped, no channel changes, err_oor<=1.
- Pop: vld[k] && out_ready[k] with no load to k in the same cycle gives vld[k]<=0 and dat[k]<=0.
- Simultaneous pop and load on the same channel: new data is loaded and vld stays 1. This gives full throughput, one beat per cycle per channel.
- Latency: 1 cycle from accept to out_valid. out_data is stable while out_valid=1 && out_ready=0.
- Channels are independent. A stalled channel never blocks beats to other channels; only beats addressed to it stall.
- err_oor: set has priority over err_clr in the same cycle. Once set, it stays set until err_clr or rst.
- Output registers are not cleared by in_valid deassertion.

Optional Feature:
- Macro: DEMUX_BCAST_EN.
- Defined:
  - When in_bcast=1, in_sel is ignored and in_ready = AND over k of free(k).
  - On accept, every channel loads in_data and sets vld. err_oor is not affected.
  - When in_bcast=0, unicast rules apply.
- Not defined: in_bcast is ignored and no broadcast logic is generated.

Test Plan:
- Reset, then N=4, W=8, all out_ready=1. Send 0xA1 to sel 0, 0xB2 to sel 1, 0xC3 to sel 2, 0xD4 to sel 3 on consecutive cycles. Expect each out_valid[k] high exactly 1 cycle after its accept with matching data; all other channels read 0.
- Hold out_ready[2]=0 and send 0x11, then 0x22, to sel 2. Expect the first accepted, in_ready=0 for the second, and out_data ch2 held at 0x11. Interleave 0x33 to sel 1 and expect it delivered with no stall. Raise out_ready[2] and expect 0x22 to follow 1 cycle later.
- Back-to-back 8 beats to sel 3 with out_ready[3]=1. Expect in_ready stuck at 1 and one output beat per cycle, in order.
- N=5: send sel=6 with data 0xFF. Expect in_ready=1, no out_valid, err_oor=1. Then pulse err_clr with another sel=7 beat in the same cycle; expect err_oor to remain 1. A second err_clr alone clears it.
- Assert rst asynchronously mid-cycle while vld[1]=1 and a beat is being accepted. Expect out_valid=0, out_data=0, err_oor=0 immediately, without waiting for a clk edge.
- DEMUX_BCAST_EN, N=4: in_bcast=1, data 0x5A, out_ready[0]=0 with ch0 full. Expect in_ready=0. Release out_ready[0] and expect all 4 channels to present 0x5A on the next cycle.
